// File: rtl/mac_sequencer.sv
// Dot-product sequencer: drives one mac instance's opcode/data bus to compute sum(a[i]*b[i]).
// 5 cycles per pair, result 4 cycles after the last ACC; in_ready only in WAIT_IN, result held until res_ready.
module mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    a_reset_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    length,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic                    in_ready,
    output logic [3:0]              mac_opcode,
    output logic [DATA_WIDTH-1:0]   mac_data,
    input  logic [DATA_WIDTH-1:0]   mac_result,
    input  logic                    mac_acc_overflow,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    res_overflow,
    output logic                    busy
);

    localparam logic [3:0] OP_RESET = 4'h0;
    localparam logic [3:0] OP_MULT  = 4'h1;
    localparam logic [3:0] OP_ACC   = 4'h2;
    localparam logic [3:0] OP_REGA  = 4'h4;
    localparam logic [3:0] OP_REGB  = 4'h5;
    localparam logic [3:0] OP_MSW   = 4'h6;
    localparam logic [3:0] OP_LSW   = 4'h7;
    localparam logic [3:0] OP_NOOP  = 4'hF;

    typedef enum logic [3:0] {
        IDLE, CLR, WAIT_IN, LDA, LDB, MUL, ACC, RD_MSW, RD_LSW, CAP, DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [LEN_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mac_opcode = OP_NOOP;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = CLR;
            end
            CLR: begin
                mac_opcode = OP_RESET;
                state_nxt  = (cnt == '0) ? RD_MSW : WAIT_IN;
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LDA;
            end
            LDA: begin
                mac_opcode = OP_REGA;
                state_nxt  = LDB;
            end
            LDB: begin
                mac_opcode = OP_REGB;
                state_nxt  = MUL;
            end
            MUL: begin
                mac_opcode = OP_MULT;
                state_nxt  = ACC;
            end
            ACC: begin
                mac_opcode = OP_ACC;
                state_nxt  = (cnt == LEN_WIDTH'(1)) ? RD_MSW : WAIT_IN;
            end
            RD_MSW: begin
                mac_opcode = OP_MSW;
                state_nxt  = RD_LSW;
            end
            RD_LSW: begin
                mac_opcode = OP_LSW;
                state_nxt  = CAP;
            end
            CAP: begin
                state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mac_data = (state == LDA) ? a_reg : b_reg;

    // mac data_out lags its opcode by one cycle, so each word is captured one state later.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            cnt          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            res_data     <= '0;
            res_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) cnt <= length;
                WAIT_IN: if (in_valid) begin
                    a_reg <= in_a;
                    b_reg <= in_b;
                end
                ACC:     cnt <= cnt - LEN_WIDTH'(1);
                RD_LSW:  res_data[2*DATA_WIDTH-1:DATA_WIDTH] <= mac_result;
                CAP: begin
                    res_data[DATA_WIDTH-1:0] <= mac_result;
                    res_overflow             <= mac_acc_overflow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboarded bench for mac_sequencer with a behavioural mac model on the opcode bus.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        a_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  length = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic        in_ready;
    logic [3:0]  mac_opcode;
    logic [7:0]  mac_data;
    logic [7:0]  mac_result;
    logic        mac_acc_overflow;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_overflow;
    logic        busy;

    mac_sequencer #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk(clk), .a_reset_n(a_reset_n), .start(start), .length(length),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mac_opcode(mac_opcode), .mac_data(mac_data), .mac_result(mac_result),
        .mac_acc_overflow(mac_acc_overflow), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_overflow(res_overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // External mac: registered, data_out updates the cycle after MSW/LSW; not cleared by a_reset_n.
    logic [7:0]  m_a = 8'd0, m_b = 8'd0, m_out = 8'd0;
    logic [15:0] m_prod = 16'd0, m_acc = 16'd0;
    logic        m_ovf = 1'b0;
    logic [16:0] m_sum;
    assign m_sum = {1'b0, m_acc} + {1'b0, m_prod};
    assign mac_result = m_out;
    assign mac_acc_overflow = m_ovf;

    always @(posedge clk) begin
        case (mac_opcode)
            4'h0: begin m_acc <= 16'd0; m_ovf <= 1'b0; end
            4'h1: m_prod <= m_a * m_b;
            4'h2: begin m_acc <= m_sum[15:0]; m_ovf <= m_ovf | m_sum[16]; end
            4'h4: m_a <= mac_data;
            4'h5: m_b <= mac_data;
            4'h6: m_out <= m_acc[15:8];
            4'h7: m_out <= m_acc[7:0];
            default: ;
        endcase
    end

    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_q[$];
    logic [7:0]  pa[$];
    logic [7:0]  pb[$];
    int          op_cnt[16];
    int          pairs_taken = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [16:0] e;
        for (int i = 0; i < 16; i++) op_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (a_reset_n) begin
                op_cnt[mac_opcode]++;
                if (in_valid && in_ready) pairs_taken++;
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", {16'd0, res_data}, {16'd0, e[15:0]});
                        check("res_overflow", {31'd0, res_overflow}, {31'd0, e[16]});
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] len);
        @(posedge clk); #1;
        start = 1'b1;
        length = len;
        @(posedge clk); #1;
        start = 1'b0;
        length = 8'hAA;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic feed(input int gap);
        while (pa.size() > 0) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                wait_ready();
                repeat (gap) begin
                    @(posedge clk); #1;
                    check("wait_in_hold", {31'd0, in_ready}, 32'd1);
                end
            end
            in_a = pa.pop_front();
            in_b = pb.pop_front();
            in_valid = 1'b1;
            wait_ready();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int exp_lat, input int hold, input bit poke, input logic [16:0] exp);
        int n = 1;
        while (!res_valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("res_valid_seen", {31'd0, res_valid}, 32'd1);
        if (exp_lat > 0) check("latency", n, exp_lat);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                start = 1'b1;
                length = 8'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("done_hold_valid", {31'd0, res_valid}, 32'd1);
            check("done_hold_data", {16'd0, res_data}, {16'd0, exp[15:0]});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("done_release", {30'd0, res_valid, busy}, 32'd0);
    endtask

    task automatic run(input logic [7:0] len, input int gap, input int exp_lat,
                       input int hold, input bit poke, input logic [16:0] exp);
        exp_q.push_back(exp);
        do_start(len);
        fork
            feed(gap);
            wait_res(exp_lat, hold, poke, exp);
        join
    endtask

    task automatic wait_op(input logic [3:0] op, input int nth);
        int seen = 0;
        for (int i = 0; i < 300 && seen < nth; i++) begin
            @(negedge clk);
            if (mac_opcode == op) seen++;
        end
        check("wait_opcode", seen, nth);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_opcode"}, {28'd0, mac_opcode}, 32'hF);
        check({tag, "_mac_data"}, {24'd0, mac_data}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_res_data"}, {16'd0, res_data}, 32'd0);
        check({tag, "_res_overflow"}, {31'd0, res_overflow}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stim
        int base[16];
        int taken0;
        #2;
        check_reset_outputs("reset");
        #20;
        a_reset_n = 1'b1;

        // T1: 1*2+3*4+5*6 = 44
        pa = '{8'd1, 8'd3, 8'd5};
        pb = '{8'd2, 8'd4, 8'd6};
        run(8'd3, 0, 20, 0, 1'b0, {1'b0, 16'h002C});

        // T2: empty dot product
        for (int i = 0; i < 16; i++) base[i] = op_cnt[i];
        run(8'd0, 0, 5, 0, 1'b0, {1'b0, 16'h0000});
        check("t2_op_reset", op_cnt[0] - base[0], 1);
        check("t2_op_rega", op_cnt[4] - base[4], 0);
        check("t2_op_msw", op_cnt[6] - base[6], 1);
        check("t2_op_lsw", op_cnt[7] - base[7], 1);

        // T3: 2*0xFE01 = 0x1FC02, carry lands in overflow
        pa = '{8'hFF, 8'hFF};
        pb = '{8'hFF, 8'hFF};
        run(8'd2, 0, 15, 0, 1'b0, {1'b1, 16'hFC02});

        // T4: 0x10*3 + 0x20*2 = 0x70 with source gaps and consumer stall
        taken0 = pairs_taken;
        pa = '{8'h10, 8'h20};
        pb = '{8'h03, 8'h02};
        run(8'd2, 3, 0, 6, 1'b0, {1'b0, 16'h0070});
        check("t4_pairs_taken", pairs_taken - taken0, 2);

        // T5: start during ACC and during DONE are ignored
        pa = '{8'd2};
        pb = '{8'd3};
        fork
            run(8'd1, 0, 10, 3, 1'b1, {1'b0, 16'h0006});
            begin
                wait_op(4'h2, 1);
                start = 1'b1;
                length = 8'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        repeat (2) begin
            @(posedge clk); #1;
            check("t5_stays_idle", {31'd0, busy}, 32'd0);
        end
        pa = '{8'd4};
        pb = '{8'd5};
        run(8'd1, 0, 10, 0, 1'b0, {1'b0, 16'h0014});

        // T6: async reset during the second MUL of a len=4 run, mac keeps its partial sum of 7
        do_start(8'd4);
        in_a = 8'd7;
        in_b = 8'd1;
        in_valid = 1'b1;
        wait_op(4'h1, 2);
        #1;
        a_reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("t6");
        @(posedge clk); #2;
        a_reset_n = 1'b1;
        pa = '{8'd7};
        pb = '{8'd9};
        run(8'd1, 0, 10, 0, 1'b0, {1'b0, 16'h003F});

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
